// File: rtl/vchip8_switch_poller.sv
// vchip8_switch_poller: polls the switch PIO and debounces it into CHIP-8 keypad state and events.
// Ports: clk, reset_n (async, active-low); avm_* Avalon-MM read master;
//   key_state (debounced levels); evt_valid/evt_data/evt_ready (show-ahead event FIFO);
//   evt_overflow (sticky drop flag), clr_overflow (clears it).
// Build option: VCHIP8_SWITCH_POLLER_EVT_FIFO_EN builds the event FIFO, EMIT state and overflow flag.
`timescale 1ns/1ps
module vchip8_switch_poller #(
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [15:0] key_state,
    output logic        evt_valid,
    output logic [4:0]  evt_data,
    input  logic        evt_ready,
    output logic        evt_overflow,
    input  logic        clr_overflow
);

    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int LW = $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_UPDATE, S_EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [15:0]     sample_q, sample_d;
    logic [15:0]     key_q, key_d;
    logic [15:0][3:0] cnt_q, cnt_d;
    logic [3:0]      inc_c;

`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [15:0]     chg_q, chg_d;
    logic [3:0]      idx_q, idx_d;
    logic [FIFO_DEPTH-1:0][4:0] mem_q, mem_d;
    logic [AW:0]     wp_q, wp_d, rp_q, rp_d;
    logic            ovf_q, ovf_d;
    logic            push, pop, full, empty, wr_en;
    logic [4:0]      push_data;
    logic [15:0]     unused_hi;

    assign unused_hi = avm_readdata[31:16];
`else
    logic            unused_in;

    assign unused_in = ^{avm_readdata[31:16], evt_ready, clr_overflow};
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            timer_q  <= TW'(POLL_DIV - 1);
            lat_q    <= '0;
            sample_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
            chg_q    <= '0;
            idx_q    <= '0;
            mem_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lat_q    <= lat_d;
            sample_q <= sample_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
            chg_q    <= chg_d;
            idx_q    <= idx_d;
            mem_q    <= mem_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lat_d    = lat_q;
        sample_d = sample_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        inc_c    = '0;
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
        chg_d    = chg_q;
        idx_d    = idx_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (timer_q == '0) begin
                    state_d = S_REQ;
                    timer_d = TW'(POLL_DIV - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = S_WAIT;
                    lat_d   = '0;
                end
            end
            S_WAIT: begin
                if (lat_q == LW'(READ_LATENCY - 1)) begin
                    sample_d = avm_readdata[15:0];
                    state_d  = S_UPDATE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_UPDATE: begin
                // A key flips only after DEBOUNCE_CNT consecutive differing samples.
                for (int n = 0; n < 16; n++) begin
                    if (sample_q[n] == key_q[n]) begin
                        cnt_d[n] = '0;
                    end else begin
                        inc_c = cnt_q[n] + 4'd1;
                        if (inc_c == 4'(DEBOUNCE_CNT)) begin
                            key_d[n] = ~key_q[n];
                            cnt_d[n] = '0;
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
                            chg_d[n] = 1'b1;
`endif
                        end else begin
                            cnt_d[n] = inc_c;
                        end
                    end
                end
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
                idx_d   = '0;
                state_d = S_EMIT;
`else
                state_d = S_IDLE;
`endif
            end
            S_EMIT: begin
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'hF) begin
                    state_d = S_IDLE;
                    chg_d   = '0;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        avm_address = 2'b00;
        avm_read    = (state_q == S_REQ);
        key_state   = key_q;
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
        push        = (state_q == S_EMIT) && chg_q[idx_q];
        push_data   = {key_q[idx_q], idx_q};
`endif
    end

`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
    // Show-ahead FIFO; the extra pointer bit separates full from empty.
    always_comb begin
        empty = (wp_q == rp_q);
        full  = (wp_q[AW] != rp_q[AW]) &&
                (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop   = !empty && evt_ready;
        wr_en = push && (!full || pop);
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wp_q[AW-1:0]] = push_data;
        end
        wp_d  = wp_q + (AW+1)'(wr_en);
        rp_d  = rp_q + (AW+1)'(pop);
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = (push && !wr_en) || (ovf_q && !clr_overflow);
    end

    assign evt_valid    = !empty;
    assign evt_data     = empty ? 5'd0 : mem_q[rp_q[AW-1:0]];
    assign evt_overflow = ovf_q;
`else
    assign evt_valid    = 1'b0;
    assign evt_data     = 5'd0;
    assign evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vchip8_switch_poller.sv
// tb_vchip8_switch_poller: directed bench for vchip8_switch_poller with a model PIO slave.
// Ports: none; drives the DUT through clk, reset_n, switch word, evt_ready and clr_overflow.
`timescale 1ns/1ps
module tb_vchip8_switch_poller;

    localparam int POLL_DIV = 8;
    localparam int DEB      = 3;
    localparam int RL       = 1;
    localparam int FD       = 4;
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
    localparam int PERIOD = POLL_DIV + 1 + RL + 1 + 16;
    localparam int SETTLE = 22;
`else
    localparam int PERIOD = POLL_DIV + 1 + RL + 1;
    localparam int SETTLE = 5;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [15:0] key_state;
    logic        evt_valid;
    logic [4:0]  evt_data;
    logic        evt_ready;
    logic        evt_overflow;
    logic        clr_overflow;

    logic [15:0] sw;
    logic        stall_arm;
    logic [2:0]  stall_left = 3'd0;
    logic [31:0] rdata = 32'd0;
    int          cyc = 0;
    int          viol = 0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    int          checks = 0;
    int          failures = 0;

    vchip8_switch_poller #(
        .POLL_DIV(POLL_DIV), .DEBOUNCE_CNT(DEB),
        .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .key_state(key_state), .evt_valid(evt_valid),
        .evt_data(evt_data), .evt_ready(evt_ready),
        .evt_overflow(evt_overflow), .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave, read latency 1, upper half filled with junk
    always @(posedge clk) begin
        if (stall_arm) stall_left <= 3'd5;
        else if (avm_read && stall_left != 0) stall_left <= stall_left - 3'd1;
        if (avm_read && !avm_waitrequest) rdata <= {16'hA5A5, sw};
    end
    assign avm_waitrequest = (stall_left != 0);
    assign avm_readdata    = rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset_n && prev_rd && prev_wr && !avm_read) viol <= viol + 1;
        prev_rd <= avm_read;
        prev_wr <= avm_waitrequest;
    end

    task automatic wait_rise(output int t, output bit ok);
        bit was;
        was = avm_read;
        ok = 1'b0;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (avm_read && !was) begin
                t = cyc;
                ok = 1'b1;
                break;
            end
            was = avm_read;
        end
    endtask

    task automatic run_polls(input int n, output bit ok);
        int t;
        bit o;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_rise(t, o);
            if (!o) ok = 1'b0;
            repeat (SETTLE) @(negedge clk);
        end
    endtask

    task automatic pop1;
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset;
        int first, second;
        bit was, bad_key, bad_val;
        reset_n = 1'b0;
        sw = 16'h0000;
        evt_ready = 1'b0;
        clr_overflow = 1'b0;
        stall_arm = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({avm_read, avm_address} !== 3'b000) begin
            failures++;
            $display("FAIL rst_read got=%b exp=000", {avm_read, avm_address});
        end
        checks++;
        if (key_state !== 16'h0000) begin
            failures++;
            $display("FAIL rst_key got=%h exp=0000", key_state);
        end
        checks++;
        if ({evt_valid, evt_data, evt_overflow} !== 7'd0) begin
            failures++;
            $display("FAIL rst_evt got=%b exp=0000000",
                     {evt_valid, evt_data, evt_overflow});
        end
        reset_n = 1'b1;
        first = -1;
        second = -1;
        was = 1'b0;
        bad_key = 1'b0;
        bad_val = 1'b0;
        for (int i = 0; i < 8 + 2 * PERIOD + 5; i++) begin
            @(negedge clk);
            if (key_state !== 16'h0000) bad_key = 1'b1;
            if (evt_valid !== 1'b0) bad_val = 1'b1;
            if (avm_read && !was) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            was = avm_read;
        end
        checks++;
        if (first != 8) begin
            failures++;
            $display("FAIL first_read got=%0d exp=8", first);
        end
        checks++;
        if (second != 8 + PERIOD) begin
            failures++;
            $display("FAIL second_read got=%0d exp=%0d", second, 8 + PERIOD);
        end
        checks++;
        if (bad_key || bad_val) begin
            failures++;
            $display("FAIL idle_quiet got=%b%b exp=00", bad_key, bad_val);
        end
    endtask

    task automatic test_glitch;
        bit ok;
        sw = 16'h0001;
        run_polls(2, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL glitch_poll got=timeout exp=read");
        end
        checks++;
        if (key_state !== 16'h0000) begin
            failures++;
            $display("FAIL glitch_key2 got=%h exp=0000", key_state);
        end
        sw = 16'h0000;
        run_polls(2, ok);
        checks++;
        if (key_state !== 16'h0000 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_end got=%h/%b exp=0000/0", key_state, evt_valid);
        end
    endtask

    task automatic test_press;
        bit ok;
        int t;
        sw = 16'h0005;
        run_polls(2, ok);
        checks++;
        if (key_state !== 16'h0000) begin
            failures++;
            $display("FAIL press_early got=%h exp=0000", key_state);
        end
        wait_rise(t, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL press_poll got=timeout exp=read");
        end
        repeat (2) @(negedge clk);
        checks++;
        if (key_state !== 16'h0000) begin
            failures++;
            $display("FAIL press_upd got=%h exp=0000", key_state);
        end
        @(negedge clk);
        checks++;
        if (key_state !== 16'h0005 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL press_key got=%h/%b exp=0005/0", key_state, evt_valid);
        end
        @(negedge clk);
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
        checks++;
        if ({evt_valid, evt_data} !== 6'b1_10000) begin
            failures++;
            $display("FAIL press_ev0 got=%b exp=110000", {evt_valid, evt_data});
        end
        repeat (SETTLE - 4) @(negedge clk);
        pop1();
        checks++;
        if ({evt_valid, evt_data} !== 6'b1_10010) begin
            failures++;
            $display("FAIL press_ev1 got=%b exp=110010", {evt_valid, evt_data});
        end
        pop1();
        checks++;
        if ({evt_valid, evt_overflow} !== 2'b00) begin
            failures++;
            $display("FAIL press_empty got=%b exp=00", {evt_valid, evt_overflow});
        end
`else
        checks++;
        if ({evt_valid, evt_data, evt_overflow} !== 7'd0) begin
            failures++;
            $display("FAIL press_tied got=%b exp=0", {evt_valid, evt_data, evt_overflow});
        end
        repeat (SETTLE - 4) @(negedge clk);
`endif
    endtask

    task automatic test_overflow;
        bit ok;
        int t;
        sw = 16'h0000;
        run_polls(3, ok);
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
        checks++;
        if ({evt_valid, evt_data} !== 6'b1_00000) begin
            failures++;
            $display("FAIL rel_ev0 got=%b exp=100000", {evt_valid, evt_data});
        end
        pop1();
        checks++;
        if ({evt_valid, evt_data} !== 6'b1_00010) begin
            failures++;
            $display("FAIL rel_ev1 got=%b exp=100010", {evt_valid, evt_data});
        end
        pop1();
        sw = 16'h003F;
        run_polls(3, ok);
        checks++;
        if (key_state !== 16'h003F || evt_overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%h/%b exp=003f/1", key_state, evt_overflow);
        end
        sw = 16'h003E;
        run_polls(2, ok);
        wait_rise(t, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ovf_poll got=timeout exp=read");
        end
        repeat (3) @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        checks++;
        if (evt_overflow !== 1'b1 || key_state !== 16'h003E) begin
            failures++;
            $display("FAIL ovf_setwins got=%b/%h exp=1/003e", evt_overflow, key_state);
        end
        repeat (5) @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        checks++;
        if (evt_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr got=%b exp=0", evt_overflow);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({evt_valid, evt_data} !== {1'b1, 5'(16 + j)}) begin
                failures++;
                $display("FAIL ovf_ev%0d got=%b exp=%b", j,
                         {evt_valid, evt_data}, {1'b1, 5'(16 + j)});
            end
            pop1();
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_empty got=%b exp=0", evt_valid);
        end
        repeat (10) @(negedge clk);
`else
        checks++;
        if (key_state !== 16'h0000) begin
            failures++;
            $display("FAIL rel_key got=%h exp=0000", key_state);
        end
        sw = 16'h003E;
        clr_overflow = 1'b1;
        evt_ready = 1'b1;
        run_polls(3, ok);
        clr_overflow = 1'b0;
        evt_ready = 1'b0;
        checks++;
        if (key_state !== 16'h003E ||
            {evt_valid, evt_data, evt_overflow} !== 7'd0) begin
            failures++;
            $display("FAIL nofifo got=%h/%b exp=003e/0", key_state,
                     {evt_valid, evt_data, evt_overflow});
        end
`endif
    endtask

    task automatic test_stall;
        bit ok;
        int r1, r2, n;
        sw = 16'h00FF;
        stall_arm = 1'b1;
        @(negedge clk);
        stall_arm = 1'b0;
        wait_rise(r1, ok);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_read) n++;
            else break;
        end
        checks++;
        if (n != 6 || !ok) begin
            failures++;
            $display("FAIL stall_len got=%0d exp=6", n);
        end
        wait_rise(r2, ok);
        checks++;
        if (r2 - r1 != PERIOD + 5) begin
            failures++;
            $display("FAIL stall_period got=%0d exp=%0d", r2 - r1, PERIOD + 5);
        end
        checks++;
        if (key_state !== 16'h003E) begin
            failures++;
            $display("FAIL stall_key1 got=%h exp=003e", key_state);
        end
        repeat (SETTLE) @(negedge clk);
        run_polls(1, ok);
        checks++;
        if (key_state !== 16'h00FF) begin
            failures++;
            $display("FAIL stall_key got=%h exp=00ff", key_state);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL read_drop got=%0d exp=0", viol);
        end
    endtask

    task automatic test_reset_mid;
        bit ok, was, bad;
        int t, first;
`ifdef VCHIP8_SWITCH_POLLER_EVT_FIFO_EN
        checks++;
        if (evt_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_valid got=%b exp=1", evt_valid);
        end
`endif
        wait_rise(t, ok);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({avm_read, key_state, evt_valid, evt_data, evt_overflow} !== 24'd0) begin
            failures++;
            $display("FAIL mid_rst got=%h exp=0",
                     {avm_read, key_state, evt_valid, evt_data, evt_overflow});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        first = -1;
        was = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (key_state !== 16'h0000 || evt_valid !== 1'b0) bad = 1'b1;
            if (avm_read && !was && first < 0) first = cyc;
            was = avm_read;
        end
        checks++;
        if (first != 8 || bad) begin
            failures++;
            $display("FAIL mid_restart got=%0d/%b exp=8/0", first, bad);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_overflow();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
